// File: rtl/score_display_scan.sv
// rtl/score_display_scan.sv - 4-digit multiplexed seven-segment driver for two 2-digit player scores
//
// Optional feature macro: SCORE_DISPLAY_BLINK_EN (display blinking driven by the blink input).
//
// Ports:
//   clk             system clock
//   reset_n         synchronous, active-low reset
//   leftscoreLeft   left player tens digit (4 bits)
//   leftscoreRight  left player units digit (4 bits)
//   rightscoreLeft  right player tens digit (4 bits)
//   rightscoreRight right player units digit (4 bits)
//   blink           blink request; only honoured when SCORE_DISPLAY_BLINK_EN is defined
//   an              anode enables, active-low, an[0] = rightmost digit
//   seg             segments a..g, active-low, seg[0] = a
//   dp              decimal point, active-low
module score_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] leftscoreLeft,
  input  logic [3:0] leftscoreRight,
  input  logic [3:0] rightscoreLeft,
  input  logic [3:0] rightscoreRight,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            PW       = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [3:0]    shadow [0:3];
  logic          tc;

  logic [3:0]    cur_digit;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic          visible;

  assign tc = (prescaler == PRE_LAST);

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;  // not a decimal digit: show a dash
    endcase
  endfunction

  // Scan timing and frame snapshot. The shadow registers load on the same
  // edge the index wraps 3->0, so every frame shows one consistent score.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescaler <= '0;
      idx       <= 2'd0;
      for (int i = 0; i < 4; i++) shadow[i] <= 4'd0;
    end else begin
      if (tc) begin
        prescaler <= '0;
        idx       <= idx + 2'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      if (tc && idx == 2'd3) begin
        shadow[0] <= rightscoreRight;
        shadow[1] <= rightscoreLeft;
        shadow[2] <= leftscoreRight;
        shadow[3] <= leftscoreLeft;
      end
    end
  end

  // Odd indices are the tens digits; a zero there is blanked but its anode
  // is still driven so the scan duty cycle stays uniform.
  always_comb begin
    cur_digit = shadow[idx];
    an_next   = ~(4'b0001 << idx);
    dp_next   = (idx != 2'd2);
    if (idx[0] && cur_digit == 4'd0) seg_next = 7'b1111111;
    else                             seg_next = seg_decode(cur_digit);
  end

`ifdef SCORE_DISPLAY_BLINK_EN
  localparam int            BW        = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          phase_on;

  always_ff @(posedge clk) begin
    if (!reset_n || !blink) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Dropping blink shows the display on the very next edge, without waiting
  // for the phase register to return to on.
  assign visible = !blink || phase_on;
`else
  logic unused_blink;
  localparam int unused_blink_div = BLINK_DIV;
  assign unused_blink = blink;
  assign visible      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= visible ? an_next : 4'b1111;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_score_display_scan.sv
// tb/tb_score_display_scan.sv - scoreboard bench for score_display_scan
module tb_score_display_scan;

  logic       clk;
  logic       reset_n;
  logic [3:0] leftscoreLeft;
  logic [3:0] leftscoreRight;
  logic [3:0] rightscoreLeft;
  logic [3:0] rightscoreRight;
  logic       blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int passed = 0;
  int total  = 0;
  int off_cnt;
  int exp_off;
  logic [11:0] exp_q [$];

  localparam logic [11:0] RST = {4'b1111, 7'b1111111, 1'b1};

  score_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .leftscoreLeft(leftscoreLeft),
    .leftscoreRight(leftscoreRight),
    .rightscoreLeft(rightscoreLeft),
    .rightscoreRight(rightscoreRight),
    .blink(blink),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
             tag, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected output for one frame: 4 cycles per digit, rightmost digit first.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int n);
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    for (int j = 0; j < n; j++) begin
      case (j / 4)
        0:       begin a = 4'b1110; s = s0; end
        1:       begin a = 4'b1101; s = s1; end
        2:       begin a = 4'b1011; s = s2; end
        default: begin a = 4'b0111; s = s3; end
      endcase
      d = (j / 4 == 2) ? 1'b0 : 1'b1;
      exp_q.push_back({a, s, d});
    end
  endtask

  task automatic tick_check(input int n, input string tag);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check_int({tag, "_queue_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_out(tag, {an, seg, dp}, e);
      end
    end
  endtask

  task automatic set_scores(input logic [3:0] ll, input logic [3:0] lr,
                            input logic [3:0] rl, input logic [3:0] rr);
    leftscoreLeft   = ll;
    leftscoreRight  = lr;
    rightscoreLeft  = rl;
    rightscoreRight = rr;
  endtask

  initial begin
    reset_n = 1'b0;
    blink   = 1'b0;
    set_scores(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 3; i++) exp_q.push_back(RST);
    tick_check(3, "reset");

    // Release; frame 0 shows the reset shadow, frame 1 shows L=1,7 R=8,6.
    reset_n = 1'b1;
    set_scores(4'd1, 4'd7, 4'd8, 4'd6);
    push_frame(7'b1000000, 7'b1111111, 7'b1000000, 7'b1111111, 16);
    push_frame(7'b0000010, 7'b0000000, 7'b1111000, 7'b1111001, 16);
    tick_check(21, "scan");

    // Change inputs during index 1: must not appear until the next frame.
    set_scores(4'd5, 4'd3, 4'd2, 4'd9);
    push_frame(7'b0010000, 7'b0100100, 7'b0110000, 7'b0010010, 16);
    tick_check(13, "snapshot");

    // Tens zero blanked, units zero shown, 12 shown as a dash.
    set_scores(4'd0, 4'd0, 4'd12, 4'd4);
`ifndef SCORE_DISPLAY_BLINK_EN
    blink = 1'b1;
`endif
    push_frame(7'b0011001, 7'b0111111, 7'b1000000, 7'b1111111, 16);
    push_frame(7'b0011001, 7'b0111111, 7'b1000000, 7'b1111111, 10);
    tick_check(40, "blank");

    // Now at index 2, prescaler 2: reset mid-scan.
    blink   = 1'b0;
    reset_n = 1'b0;
    exp_q.push_back(RST);
    tick_check(1, "midreset");
    reset_n = 1'b1;
    push_frame(7'b1000000, 7'b1111111, 7'b1000000, 7'b1111111, 4);
    tick_check(4, "restart");

`ifdef SCORE_DISPLAY_BLINK_EN
    exp_off = 8;
`else
    exp_off = 0;
`endif
    blink   = 1'b1;
    off_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (an === 4'b1111) off_cnt++;
    end
    check_int("blink_off_cycles", off_cnt, exp_off);

    blink = 1'b0;
    @(posedge clk);
    #1;
    check_int("blink_drop_visible", int'(an === 4'b1111), 0);

    check_int("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
